// File: rtl/phy_rx_deserializer.sv
// Byte-stream receiver: finds frame phase from idle symbols and rebuilds 4 lanes.
// Optional macro PHY_RX_ERR_CNT_EN adds err_count (valid idle symbols while aligned).
module phy_rx_deserializer #(
    parameter logic [7:0]  IDLE_SYM   = 8'hBC,
    parameter int unsigned SYNC_COUNT = 8
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic [7:0] data_out_0,
    output logic [7:0] data_out_1,
    output logic [7:0] data_out_2,
    output logic [7:0] data_out_3,
    output logic       valid_out_0,
    output logic       valid_out_1,
    output logic       valid_out_2,
    output logic       valid_out_3,
`ifdef PHY_RX_ERR_CNT_EN
    output logic [7:0] err_count,
`endif
    output logic       frame_strobe,
    output logic       active
);

    typedef enum logic [1:0] {HUNT, ARMED, ALIGNED} state_e;

    localparam logic [7:0] SYNC_CNT8 = 8'(SYNC_COUNT);

    state_e          state_q, state_d;
    logic [7:0]      idle_q, idle_d;
    logic [1:0]      slot_q, slot_d;
    logic [2:0][7:0] shd_q, shd_d;
    logic [2:0]      shv_q, shv_d;
    logic [3:0][7:0] out_q, out_d;
    logic [3:0]      vout_q, vout_d;
    logic            strobe_q, strobe_d;

    logic [7:0] byte_in;
    logic       is_idle;

    assign byte_in = valid_in ? data_in : 8'h00;
    assign is_idle = !valid_in && (data_in == IDLE_SYM);

    // Sync FSM, slot capture and frame release
    always_comb begin
        state_d  = state_q;
        idle_d   = idle_q;
        slot_d   = slot_q;
        shd_d    = shd_q;
        shv_d    = shv_q;
        out_d    = out_q;
        vout_d   = vout_q;
        strobe_d = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (is_idle) begin
                    if (idle_q != SYNC_CNT8) begin
                        idle_d = idle_q + 8'd1;
                    end
                    if (idle_q + 8'd1 == SYNC_CNT8) begin
                        state_d = ARMED;
                    end
                end else begin
                    idle_d = 8'd0;
                end
            end
            ARMED: begin
                if (valid_in) begin
                    shd_d[0] = data_in;
                    shv_d[0] = 1'b1;
                    slot_d   = 2'd1;
                    state_d  = ALIGNED;
                end
            end
            ALIGNED: begin
                slot_d = slot_q + 2'd1;
                unique case (slot_q)
                    2'd0: begin
                        shd_d[0] = byte_in;
                        shv_d[0] = valid_in;
                    end
                    2'd1: begin
                        shd_d[1] = byte_in;
                        shv_d[1] = valid_in;
                    end
                    2'd2: begin
                        shd_d[2] = byte_in;
                        shv_d[2] = valid_in;
                    end
                    default: begin
                        out_d[0]  = shd_q[0];
                        out_d[2]  = shd_q[1];
                        out_d[1]  = shd_q[2];
                        out_d[3]  = byte_in;
                        vout_d[0] = shv_q[0];
                        vout_d[2] = shv_q[1];
                        vout_d[1] = shv_q[2];
                        vout_d[3] = valid_in;
                        strobe_d  = 1'b1;
                        if (shv_q == 3'b000 && !valid_in) begin
                            state_d = ARMED;
                        end
                    end
                endcase
            end
            default: state_d = HUNT;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= HUNT;
            idle_q   <= 8'd0;
            slot_q   <= 2'd0;
            shd_q    <= '0;
            shv_q    <= '0;
            out_q    <= '0;
            vout_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            slot_q   <= slot_d;
            shd_q    <= shd_d;
            shv_q    <= shv_d;
            out_q    <= out_d;
            vout_q   <= vout_d;
            strobe_q <= strobe_d;
        end
    end

`ifdef PHY_RX_ERR_CNT_EN
    logic [7:0] err_q, err_d;

    // Saturating count of valid idle symbols seen while aligned
    always_comb begin
        err_d = err_q;
        if (state_q == ALIGNED && valid_in && data_in == IDLE_SYM
            && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    // Error counter register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err_q <= 8'd0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`endif

    assign data_out_0   = out_q[0];
    assign data_out_1   = out_q[1];
    assign data_out_2   = out_q[2];
    assign data_out_3   = out_q[3];
    assign valid_out_0  = vout_q[0];
    assign valid_out_1  = vout_q[1];
    assign valid_out_2  = vout_q[2];
    assign valid_out_3  = vout_q[3];
    assign frame_strobe = strobe_q;
    assign active       = (state_q == ALIGNED);

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// Directed bench for phy_rx_deserializer.
// Define PHY_RX_ERR_CNT_EN to also exercise err_count.
module tb_phy_rx_deserializer;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [7:0] data_in;
    logic       valid_in;
    logic [7:0] data_out_0, data_out_1, data_out_2, data_out_3;
    logic       valid_out_0, valid_out_1, valid_out_2, valid_out_3;
    logic       frame_strobe, active;
`ifdef PHY_RX_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int strobe_cnt = 0;

    always #5 clk = ~clk;

    phy_rx_deserializer dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .data_out_0   (data_out_0),
        .data_out_1   (data_out_1),
        .data_out_2   (data_out_2),
        .data_out_3   (data_out_3),
        .valid_out_0  (valid_out_0),
        .valid_out_1  (valid_out_1),
        .valid_out_2  (valid_out_2),
        .valid_out_3  (valid_out_3),
`ifdef PHY_RX_ERR_CNT_EN
        .err_count    (err_count),
`endif
        .frame_strobe (frame_strobe),
        .active       (active)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // drive one byte, step one edge, sample 1ns later
    task automatic send(input logic v, input logic [7:0] d);
        valid_in = v;
        data_in  = d;
        @(posedge clk);
        #1;
        if (frame_strobe === 1'b1) strobe_cnt++;
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 8'hBC);
    endtask

    task automatic chk_lanes(input string tag,
                             input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3,
                             input logic [3:0] v);
        check({tag, "_d0"}, 32'(data_out_0), 32'(d0));
        check({tag, "_d1"}, 32'(data_out_1), 32'(d1));
        check({tag, "_d2"}, 32'(data_out_2), 32'(d2));
        check({tag, "_d3"}, 32'(data_out_3), 32'(d3));
        check({tag, "_v"},
              32'({valid_out_3, valid_out_2, valid_out_1, valid_out_0}),
              32'(v));
    endtask

    initial begin
        reset_L  = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_lanes("rst", 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
        check("rst_strobe", 32'(frame_strobe), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        @(negedge clk);
        reset_L = 1'b1;

        // basic lock and first frame
        idles(8);
        check("armed_active", 32'(active), 32'd0);
        send(1'b1, 8'h10);
        check("aligned_active", 32'(active), 32'd1);
        send(1'b1, 8'h20);
        send(1'b1, 8'h30);
        check("no_early_strobe", 32'(frame_strobe), 32'd0);
        send(1'b1, 8'h40);
        check("f1_strobe", 32'(frame_strobe), 32'd1);
        chk_lanes("f1", 8'h10, 8'h30, 8'h20, 8'h40, 4'hF);

        // mixed-valid frame, outputs hold until next strobe
        send(1'b1, 8'hA1);
        check("strobe_one_cycle", 32'(frame_strobe), 32'd0);
        check("hold_d0", 32'(data_out_0), 32'h10);
        send(1'b0, 8'hBC);
        send(1'b1, 8'hA3);
        send(1'b0, 8'hBC);
        check("f2_strobe", 32'(frame_strobe), 32'd1);
        chk_lanes("f2", 8'hA1, 8'hA3, 8'h00, 8'h00, 4'h3);
        check("f2_active", 32'(active), 32'd1);

        // all-idle frame de-aligns, next valid byte becomes lane 0
        idles(4);
        check("f3_strobe", 32'(frame_strobe), 32'd1);
        chk_lanes("f3", 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
        check("dealign_active", 32'(active), 32'd0);
        idles(2);
        check("armed_wait", 32'(active), 32'd0);
        send(1'b1, 8'h55);
        check("realign_active", 32'(active), 32'd1);
        send(1'b1, 8'h66);
        send(1'b1, 8'h77);
        send(1'b1, 8'h88);
        check("f4_strobe", 32'(frame_strobe), 32'd1);
        chk_lanes("f4", 8'h55, 8'h77, 8'h66, 8'h88, 4'hF);

`ifdef PHY_RX_ERR_CNT_EN
        check("err_zero", 32'(err_count), 32'd0);
        for (int i = 0; i < 3; i++) send(1'b1, 8'hBC);
        check("err_three", 32'(err_count), 32'd3);
        for (int i = 0; i < 297; i++) send(1'b1, 8'hBC);
        check("err_sat", 32'(err_count), 32'hFF);
        check("err_active", 32'(active), 32'd1);
`endif

        // reset in the middle of a frame
        send(1'b1, 8'hC1);
        send(1'b1, 8'hC2);
        reset_L = 1'b0;
        #2;
        chk_lanes("mid_rst", 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
        check("mid_rst_active", 32'(active), 32'd0);
        check("mid_rst_strobe", 32'(frame_strobe), 32'd0);
        @(negedge clk);
        reset_L = 1'b1;
        strobe_cnt = 0;
        for (int i = 0; i < 8; i++) send(1'b1, 8'(8'hD0 + i));
        check("hunt_no_strobe", 32'(strobe_cnt), 32'd0);
        check("hunt_active", 32'(active), 32'd0);

        // 7 idles then a dirty symbol: must stay hunting
        idles(7);
        send(1'b0, 8'h00);
        for (int i = 0; i < 8; i++) send(1'b1, 8'(8'hE0 + i));
        check("short_sync_strobe", 32'(strobe_cnt), 32'd0);
        check("short_sync_active", 32'(active), 32'd0);

        // clean resync
        idles(8);
        send(1'b1, 8'hF1);
        send(1'b1, 8'hF2);
        send(1'b1, 8'hF3);
        send(1'b1, 8'hF4);
        check("resync_strobe", 32'(frame_strobe), 32'd1);
        check("resync_count", 32'(strobe_cnt), 32'd1);
        chk_lanes("resync", 8'hF1, 8'hF3, 8'hF2, 8'hF4, 4'hF);
        check("resync_active", 32'(active), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/phy_rx_deserializer.md
Name: phy_rx_deserializer

Overview:
- Receive-side counterpart of the lane-interleaving transmit path.
- Takes one byte stream, one byte per clk cycle at the fast (4f) rate, and rebuilds the four 8-bit lanes with their valids.
- Delivers one full 4-lane frame every 4 cycles.
- A sync FSM uses idle symbols on the line to find the frame phase before any frame is released.

Parameters:
- IDLE_SYM, 8'hBC, byte the transmitter sends in any slot whose lane is invalid.
- SYNC_COUNT, 8, consecutive idle symbols required before the receiver arms for alignment.

Ports:
- clk  input  1  single clock, fast byte rate
- reset_L  input  1  asynchronous, active-low reset
- data_in  input  8  serial byte stream
- valid_in  input  1  byte in data_in is lane data
- data_out_0  output  8  lane 0 byte of last complete frame
- data_out_1  output  8  lane 1 byte
- data_out_2  output  8  lane 2 byte
- data_out_3  output  8  lane 3 byte
- valid_out_0  output  1  lane 0 valid
- valid_out_1  output  1  lane 1 valid
- valid_out_2  output  1  lane 2 valid
- valid_out_3  output  1  lane 3 valid
- frame_strobe  output  1  one-cycle pulse: new frame on the lane outputs
- active  output  1  receiver is in ALIGNED

Behaviour:
- Clock and reset: one clock, clk. reset_L is asynchronous and active-low.
- Reset values: all data_out_N = 8'h00, all valid_out_N = 0, frame_strobe = 0, active = 0. FSM enters HUNT, slot counter = 0, idle counter = 0.
- Slot-to-lane map is fixed by the transmit mux tree: slot0→lane0, slot1→lane2, slot2→lane1, slot3→lane3.
- HUNT state:
  - idle counter increments when valid_in=0 and data_in==IDLE_SYM.
  - Any other input clears the idle counter.
  - When the counter reaches SYNC_COUNT, go to ARMED. Counter saturates and is not compared again.
- ARMED state:
  - Waits for the first cycle with valid_in=1.
  - That byte is captured as slot 0. Slot counter becomes 1 and the FSM goes to ALIGNED in the same edge.
- ALIGNED state:
  - Slot counter increments mod 4 every cycle.
  - Every byte is captured into the shadow register for its slot as {valid_in, data_in}. data is stored as 8'h00 when valid_in=0.
  - When slot 3 is captured, on that same edge the four shadow entries (slot 3 taken directly from the input) are copied to the lane outputs via the slot map. frame_strobe is 1 for exactly the following cycle.
- Latency: the last byte of a frame appears on the lane outputs 1 cycle after its input cycle.
- Lane outputs hold their value between strobes.
- De-alignment: when a completed frame has all four valids = 0, that frame is still output (all valid_out=0). The FSM then returns to ARMED and active drops on the same edge.
- A valid byte arriving while in HUNT is ignored.
- Reset asserted mid-frame: partial shadow contents are discarded and outputs return to reset values immediately.
- active = 1 only in ALIGNED.

Optional Feature:
- Macro: PHY_RX_ERR_CNT_EN
- When defined:
  - Adds output err_count, 8 bits.
  - Increments for each cycle in ALIGNED with valid_in=1 and data_in==IDLE_SYM, saturating at 8'hFF.
  - Reset to 0 by reset_L.
- When undefined: the port and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset then 8 cycles of {valid_in=0, data_in=8'hBC}, then bytes 8'h10,8'h20,8'h30,8'h40 all valid → after 4th byte +1 cycle: data_out_0=10, data_out_2=20, data_out_1=30, data_out_3=40, all valid_out=1, frame_strobe=1 for one cycle, active=1.
- Only 7 idles, then one non-idle invalid byte, then valid data → no frame_strobe and active=0. Receiver stays in HUNT until 8 clean idles.
- Aligned; frame of slots valid/invalid/valid/invalid with data A1,BC,A3,BC → data_out_0=A1, data_out_1=A3, valid_out_2=valid_out_3=0, data_out_2=data_out_3=00.
- Aligned; full idle frame (4×BC, valid 0) → strobe with all valid_out=0, active falls. Next valid byte 8'h55 re-aligns as lane 0.
- reset_L pulsed low after slot 1 of a frame → outputs immediately 0, FSM in HUNT, no strobe until resync.
- With PHY_RX_ERR_CNT_EN: in ALIGNED, send valid_in=1 with data_in=8'hBC three times → err_count=3. Send it 300 times → err_count=8'hFF.
